// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS instruction classes, opcode/func constants and encoder state type
// Used by instr_word_pack, instr_encoder and the control decoder.
package mips_pkg;

    typedef enum logic [3:0] {
        CL_ADD  = 4'd0,
        CL_AND  = 4'd1,
        CL_OR   = 4'd2,
        CL_SLT  = 4'd3,
        CL_SLL  = 4'd4,
        CL_JR   = 4'd5,
        CL_ADDI = 4'd6,
        CL_ORI  = 4'd7,
        CL_LW   = 4'd8,
        CL_SW   = 4'd9,
        CL_BEQ  = 4'd10,
        CL_J    = 4'd11,
        CL_JAL  = 4'd12
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } enc_state_e;

    // Classes above JAL have no encoding and are rejected by the packer.
    function automatic logic class_known(input logic [3:0] cls);
        return cls <= 4'(CL_JAL);
    endfunction

endpackage

// File: rtl/instr_word_pack.sv
// instr_word_pack: combinational packing of an instruction class plus fields into a 32-bit MIPS word
// Ports: cls (class), rs/rt/rd/shamt, imm, target in; word (encoded instruction), valid (class known) out.
module instr_word_pack
    import mips_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        valid
);

    always_comb begin
        word  = '0;
        valid = class_known(cls);
        case (cls)
            CL_ADD:  word = {OP_RTYPE, rs, rt, rd, shamt, FN_ADD};
            CL_AND:  word = {OP_RTYPE, rs, rt, rd, shamt, FN_AND};
            CL_OR:   word = {OP_RTYPE, rs, rt, rd, shamt, FN_OR};
            CL_SLT:  word = {OP_RTYPE, rs, rt, rd, shamt, FN_SLT};
            // Shifts take their source from rt; the rs slot is architecturally zero.
            CL_SLL:  word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
            CL_JR:   word = {OP_RTYPE, rs, 15'd0, FN_JR};
            CL_ADDI: word = {OP_ADDI, rs, rt, imm};
            CL_ORI:  word = {OP_ORI, rs, rt, imm};
            CL_LW:   word = {OP_LW, rs, rt, imm};
            CL_SW:   word = {OP_SW, rs, rt, imm};
            CL_BEQ:  word = {OP_BEQ, rs, rt, imm};
            CL_J:    word = {OP_J, target};
            CL_JAL:  word = {OP_JAL, target};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams encoded MIPS instructions into an instruction memory, one word per cycle
// Ports: clk, reset (sync, active-high); start/base_addr/max_words open a session;
// in_valid/in_ready handshake with in_class, in_rs/rt/rd/shamt, in_imm, in_target, in_last;
// imem_we/imem_addr/imem_wdata memory write port; busy, done (pulse), overflow and
// bad_class (sticky), word_count (words written this session).
module instr_encoder
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [7:0]  max_words,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_class,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    input  logic        in_last,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        bad_class,
    output logic [8:0]  word_count
);

    enc_state_e  state;
    logic [31:0] next_addr;
    logic [8:0]  limit;
    logic [31:0] word;
    logic        word_ok;
    logic [9:0]  inflight;
    logic        accept;
    logic        fills;

    instr_word_pack u_pack (
        .cls    (in_class),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .imm    (in_imm),
        .target (in_target),
        .word   (word),
        .valid  (word_ok)
    );

    // word_count only commits once a write has been presented, so the write
    // currently on the port is counted here to keep in_ready exact.
    assign inflight = {1'b0, word_count} + {9'd0, imem_we};
    assign in_ready = (state == S_LOAD) && (inflight < {1'b0, limit});
    assign accept   = in_valid && in_ready;
    assign fills    = (inflight + 10'd1) == {1'b0, limit};
    assign busy     = state != S_IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            next_addr  <= '0;
            limit      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            bad_class  <= 1'b0;
            word_count <= '0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            if (imem_we) word_count <= word_count + 9'd1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        next_addr  <= base_addr;
                        limit      <= (max_words == 8'd0) ? 9'd256 : {1'b0, max_words};
                        word_count <= '0;
                        overflow   <= 1'b0;
                        bad_class  <= 1'b0;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (word_ok) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= next_addr;
                            imem_wdata <= word;
                            next_addr  <= next_addr + 32'd4;
                        end else begin
                            bad_class <= 1'b1;
                        end
                        // Filling the limit on the in_last beat is a clean finish, not an overflow.
                        if (in_last) begin
                            state <= S_DRAIN;
                        end else if (word_ok && fills) begin
                            overflow <= 1'b1;
                            state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The final write is on the port during this cycle; it completes at this edge.
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: start  in  1  begin load session; base_addr  in  32  first write address, word-aligned; max_words  in  8  session word limit, 0 = 256.
REQ-003 SHALL have ports: in_valid  in  1; in_ready  out  1; in_class  in  4  instruction class; in_rs, in_rt, in_rd, in_shamt  in  5 each; in_imm  in  16; in_target  in  26; in_last  in  1  final beat of the session.
REQ-004 SHALL have ports: imem_we  out  1; imem_addr  out  32; imem_wdata  out  32  instruction-memory write port.
REQ-005 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; overflow  out  1  sticky; bad_class  out  1  sticky; word_count  out  9  words written this session.

Function
REQ-006 SHALL use states IDLE, LOAD and DRAIN.
REQ-007 IDLE: start=1 SHALL load address to base_addr, clear word_count, overflow and bad_class, and enter LOAD next cycle.
REQ-008 in_ready SHALL be 1 only in LOAD with word_count plus pending writes below the limit; a beat is accepted when in_valid and in_ready are both 1 on a clock edge.
REQ-009 An accepted beat SHALL be encoded and registered, with imem_we=1, imem_addr=current address and imem_wdata=the encoded word exactly one cycle after acceptance; the address then increments by 4 and word_count by 1.
REQ-010 Back-to-back beats SHALL sustain one write per cycle.
REQ-011 Encoding for R-type SHALL be {000000, rs, rt, rd, shamt, func}, with func: ADD(0)=100000, AND(1)=100100, OR(2)=100101, SLT(3)=101010, SLL(4)=000000 (rs forced to 0).
REQ-012 Encoding for JR(5) SHALL be {000000, rs, 15'b0, 001000}.
REQ-013 Encoding for I-type SHALL be {op, rs, rt, imm}, with op: ADDI(6)=001000, ORI(7)=001101, LW(8)=100011, SW(9)=101011, BEQ(10)=000100.
REQ-014 Encoding for J-type SHALL be {op, target}, with op: J(11)=000010, JAL(12)=000011.
REQ-015 Classes 13-15 SHALL be consumed without a write and without an address or count change, and SHALL set bad_class.
REQ-016 An accepted beat with in_last=1 SHALL move the block to DRAIN; done SHALL pulse in the cycle after the final write, and the block SHALL then return to IDLE.
REQ-017 A bad-class beat with in_last=1 SHALL also move the block to DRAIN and complete the session without a write.
REQ-018 When word_count reaches the limit without in_last, in_ready SHALL drop, overflow SHALL set, and the block SHALL go to DRAIN and then pulse done.
REQ-019 If the limit is reached and in_last arrives on the same beat, overflow SHALL stay 0.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 busy SHALL be 1 in LOAD and DRAIN.
REQ-022 imem_addr SHALL wrap modulo 2^32.

Reset
REQ-023 reset SHALL override every other input on the same edge and abort any session in progress, including a pending write.
REQ-024 After reset: state=IDLE; in_ready, imem_we, busy, done, overflow and bad_class = 0; imem_addr and imem_wdata = 0; word_count = 0.

Structure
REQ-025 Class enumeration, opcode constants and func constants SHALL reside in shared package mips_pkg, which the control decoder also uses.
REQ-026 Field packing SHALL be a combinational sub-module instr_word_pack (class plus fields in, 32-bit word and valid flag out); sequencing SHALL remain in instr_encoder.

Verification
REQ-027 start with base_addr=0x00400000, then ADDI rs=0 rt=8 imm=5 with in_last=1 -> imem_we=1 one cycle later, addr 0x00400000, data 0x20080005; done pulses the next cycle.
REQ-028 Back-to-back beats ADD rd=10 rs=8 rt=9, then LW rt=9 rs=8 imm=4, then JAL target=0x100 -> data 0x01095020, 0x8D090004 and 0x0C000100 on three consecutive cycles at addrs +0, +4 and +8.
REQ-029 max_words=2 with 3 beats offered, none with in_last -> exactly 2 writes, in_ready=0 afterwards, overflow=1, done pulses once.
REQ-030 Class 14 beat between two ADDI beats -> 2 writes at consecutive addresses, bad_class=1, word_count=2.
REQ-031 reset asserted in the cycle after acceptance -> no write occurs; all outputs match REQ-024; a subsequent start works normally.
REQ-032 base_addr=0xFFFFFFFC with 2 beats -> writes at 0xFFFFFFFC and then 0x00000000.
